serial_compare_sequencer: RTL and testbench
===========================================

// Module: serial_compare_sequencer
// PURPOSE
//  Sequencer for the bit-serial magnitude comparator (x, y, reset, clk -> gt, lt).
//  Accepts two WIDTH-bit words on a valid/ready handshake and clears the comparator.
//  Shifts both words into it MSB-first, one bit per clk, then returns gt/lt/eq on a second valid/ready handshake.
//  Sits between a parallel-word producer and the serial comparator instance.
// PARAMETERS
//  WIDTH  4  operand width in bits; legal range 1..32
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-low reset (0 = reset)
//  start_valid  in   1      operand pair a/b is valid
//  start_ready  out  1      sequencer can accept an operand pair
//  a            in   WIDTH  operand driven onto comparator x
//  b            in   WIDTH  operand driven onto comparator y
//  cmp_rst      out  1      active-high clear to comparator reset input
//  cmp_x        out  1      serial bit of a, MSB first
//  cmp_y        out  1      serial bit of b, MSB first
//  cmp_gt       in   1      comparator gt; Mealy, reflects the bit currently presented
//  cmp_lt       in   1      comparator lt; Mealy, reflects the bit currently presented
//  res_valid    out  1      result valid
//  res_ready    in   1      consumer accepts result
//  res_gt       out  1      a > b
//  res_lt       out  1      a < b
//  res_eq       out  1      a == b
//  busy         out  1      1 whenever state != IDLE
//  proto_err    out  1      sticky: cmp_gt and cmp_lt were both 1 at a sample point
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; shift regs, bit counter and result regs = 0.
//   Outputs: start_ready=1, cmp_rst=0, cmp_x=cmp_y=0, res_valid=0,
//   res_gt=res_lt=res_eq=0, busy=0, proto_err=0.
//   Reset mid-operation aborts any transfer immediately; no partial result is produced.
//  FSM states: IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
//   IDLE:  start_ready=1. On start_valid at an edge, capture a->sa, b->sb and cnt=WIDTH-1; go CLEAR.
//   CLEAR: exactly 1 cycle. cmp_rst=1, cmp_x=cmp_y=0, start_ready=0. Next state SHIFT.
//   SHIFT: WIDTH cycles. cmp_x=sa[WIDTH-1], cmp_y=sb[WIDTH-1], cmp_rst=0.
//     Each edge with cnt!=0: sa<<=1, sb<<=1 (zero-fill), cnt-=1.
//     Edge with cnt==0: capture res_gt=cmp_gt, res_lt=cmp_lt, res_eq=~cmp_gt&~cmp_lt.
//     If cmp_gt&cmp_lt: set proto_err; res_gt=res_lt=0, res_eq=0. Next state DONE.
//   DONE:  res_valid=1; res_* stable. Leave for IDLE on the edge where res_ready=1.
//     With res_ready=0, hold all outputs indefinitely.
//  cmp_x, cmp_y, cmp_rst, start_ready, res_valid, busy: combinational decode of state and shift-reg MSBs.
//  Latency: accept edge at cycle 0; CLEAR in cycle 1; SHIFT in cycles 2..WIDTH+1; res_valid from cycle WIDTH+2.
//   Back-to-back throughput: one pair per WIDTH+3 cycles (one IDLE cycle between ops).
//  start_valid outside IDLE is ignored; a/b are not sampled outside the IDLE accept edge.
//  Widths: cnt is max(1,$clog2(WIDTH)) bits; for WIDTH=1, SHIFT lasts 1 cycle with cnt==0.
//  proto_err clears only on reset.
//  The comparator must be instantiated with its reset tied to cmp_rst.
// TESTING  (WIDTH=4, real comparator instance unless noted)
//  1. a=4'b1010, b=4'b0110, res_ready=1:
//     cmp_x seq 1,0,1,0; cmp_y seq 0,1,1,0; res_valid at cycle 6; gt=1 lt=0 eq=0.
//  2. a=4'b0011, b=4'b0101 -> res_lt=1 gt=0 eq=0. a=b=4'b1001 -> res_eq=1. a=b=0 -> res_eq=1.
//  3. Backpressure: hold res_ready=0 for 5 cycles after res_valid.
//     Result must stay stable, start_ready=0, new start_valid ignored.
//     After res_ready=1: IDLE next cycle.
//  4. Reset mid-SHIFT (drive reset=0 between edges after 2 bits):
//     All outputs reach reset values without a clk edge.
//     After release, a=4'b1111, b=4'b0000 -> res_gt=1.
//  5. 10 back-to-back random pairs, start_valid held high:
//     Accepts spaced exactly 7 cycles apart; each result matches $signed-free integer compare.
//  6. Behavioural comparator model forcing cmp_gt=cmp_lt=1 on the last bit:
//     proto_err=1 and sticky; res_gt=res_lt=res_eq=0.

Source files
------------

// File: rtl/serial_compare_sequencer.sv
// Sequencer that feeds a bit-serial magnitude comparator MSB-first from a
// parallel operand pair and returns its gt/lt/eq verdict on a valid/ready port.
module serial_compare_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_rst,
  output logic             cmp_x,
  output logic             cmp_y,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_gt,
  output logic             res_lt,
  output logic             res_eq,
  output logic             busy,
  output logic             proto_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking here would chain updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      res_gt    <= 1'b0;
      res_lt    <= 1'b0;
      res_eq    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            sa    <= a;
            sb    <= b;
            cnt   <= CW'(WIDTH - 1);
            state <= CLEAR;
          end
        end

        CLEAR: state <= SHIFT;

        SHIFT: begin
          if (cnt != '0) begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt - CW'(1);
          end else begin
            // The comparator is Mealy: its outputs already include the LSB now on x/y.
            if (cmp_gt && cmp_lt) begin
              proto_err <= 1'b1;
              res_gt    <= 1'b0;
              res_lt    <= 1'b0;
              res_eq    <= 1'b0;
            end else begin
              res_gt    <= cmp_gt;
              res_lt    <= cmp_lt;
              res_eq    <= ~cmp_gt & ~cmp_lt;
            end
            state <= DONE;
          end
        end

        DONE: begin
          if (res_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign cmp_rst     = (state == CLEAR);
  assign cmp_x       = (state == SHIFT) & sa[WIDTH-1];
  assign cmp_y       = (state == SHIFT) & sb[WIDTH-1];
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Self-checking bench: directed vector table plus hand-written sequences for
// backpressure, mid-operation reset, back-to-back throughput and protocol error.
module tb_serial_compare_sequencer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cmp_rst;
  logic             cmp_x;
  logic             cmp_y;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             res_valid;
  logic             res_ready;
  logic             res_gt;
  logic             res_lt;
  logic             res_eq;
  logic             busy;
  logic             proto_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_compare_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cmp_rst     (cmp_rst),
    .cmp_x       (cmp_x),
    .cmp_y       (cmp_y),
    .cmp_gt      (cmp_gt),
    .cmp_lt      (cmp_lt),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_gt      (res_gt),
    .res_lt      (res_lt),
    .res_eq      (res_eq),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  // Behavioural MSB-first serial comparator: once a differing bit is seen the
  // verdict latches; outputs are Mealy on the bit currently presented.
  logic cm_gt_r, cm_lt_r, gt_raw, lt_raw, force_both;

  assign gt_raw = cm_gt_r | (~cm_gt_r & ~cm_lt_r & cmp_x & ~cmp_y);
  assign lt_raw = cm_lt_r | (~cm_gt_r & ~cm_lt_r & ~cmp_x & cmp_y);
  assign cmp_gt = force_both ? 1'b1 : gt_raw;
  assign cmp_lt = force_both ? 1'b1 : lt_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cm_gt_r <= 1'b0;
      cm_lt_r <= 1'b0;
    end else if (cmp_rst) begin
      cm_gt_r <= 1'b0;
      cm_lt_r <= 1'b0;
    end else begin
      cm_gt_r <= gt_raw;
      cm_lt_r <= lt_raw;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             gt;
    logic             lt;
    logic             eq;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " start_ready"}, start_ready, 1);
    check({tag, " cmp_rst"},     cmp_rst,     0);
    check({tag, " cmp_x"},       cmp_x,       0);
    check({tag, " cmp_y"},       cmp_y,       0);
    check({tag, " res_valid"},   res_valid,   0);
    check({tag, " res_gt"},      res_gt,      0);
    check({tag, " res_lt"},      res_lt,      0);
    check({tag, " res_eq"},      res_eq,      0);
    check({tag, " busy"},        busy,        0);
    check({tag, " proto_err"},   proto_err,   0);
  endtask

  // Entered at a negedge in IDLE; returns at the negedge of the first DONE cycle
  // (cycle WIDTH+2 counting the accept edge as cycle 0).
  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic eg, input logic el, input logic ee, input logic ep,
                        input bit force_last, input string tag);
    check({tag, " start_ready"}, start_ready, 1);
    a = va;
    b = vb;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    check({tag, " clear cmp_rst"}, cmp_rst, 1);
    check({tag, " clear cmp_x"},   cmp_x,   0);
    check({tag, " clear busy"},    busy,    1);
    check({tag, " clear ready"},   start_ready, 0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check({tag, " shift cmp_rst"}, cmp_rst, 0);
      check({tag, " shift cmp_x"},   cmp_x, va[WIDTH-1-i]);
      check({tag, " shift cmp_y"},   cmp_y, vb[WIDTH-1-i]);
      check({tag, " shift res_valid"}, res_valid, 0);
      if (force_last && i == WIDTH - 1) force_both = 1'b1;
    end
    @(negedge clk);
    force_both = 1'b0;
    check({tag, " res_valid"}, res_valid, 1);
    check({tag, " res_gt"},    res_gt,    eg);
    check({tag, " res_lt"},    res_lt,    el);
    check({tag, " res_eq"},    res_eq,    ee);
    check({tag, " proto_err"}, proto_err, ep);
  endtask

  logic [WIDTH-1:0] pa[10];
  logic [WIDTH-1:0] pb[10];

  initial begin
    vecs[0] = '{4'b1010, 4'b0110, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 4'b0101, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b1001, 4'b1001, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b0111, 4'b1000, 1'b0, 1'b1, 1'b0};

    reset       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    force_both  = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    // Directed table, result consumed immediately.
    for (int k = 0; k < 6; k++) begin
      run_op(vecs[k].va, vecs[k].vb, vecs[k].gt, vecs[k].lt, vecs[k].eq, 1'b0, 1'b0,
             $sformatf("vec%0d", k));
      @(negedge clk);
      check($sformatf("vec%0d back to idle", k), busy, 0);
    end

    // Backpressure: result held, new start ignored.
    res_ready = 1'b0;
    run_op(4'b0101, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bp");
    a = 4'b0000;
    b = 4'b1111;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp res_valid", res_valid, 1);
      check("bp res_gt", res_gt, 1);
      check("bp res_lt", res_lt, 0);
      check("bp start_ready", start_ready, 0);
    end
    res_ready   = 1'b1;
    start_valid = 1'b0;
    @(negedge clk);
    check("bp idle busy", busy, 0);
    check("bp idle ready", start_ready, 1);
    check("bp idle res_valid", res_valid, 0);

    // Asynchronous reset in the third SHIFT cycle, between clock edges.
    a = 4'b1010;
    b = 4'b0110;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset cmp_x", cmp_x, 1);
    #2 reset = 1'b0;
    #1 check_reset_vals("mid reset");
    @(negedge clk);
    reset = 1'b1;
    run_op(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "after reset");
    @(negedge clk);

    // Back-to-back random pairs with start_valid held high.
    begin
      int idx, ridx, last_acc;
      bit done;
      idx = 0; ridx = 0; last_acc = 0; done = 1'b0;
      for (int i = 0; i < 10; i++) begin
        pa[i] = WIDTH'($urandom_range(0, 15));
        pb[i] = WIDTH'($urandom_range(0, 15));
      end
      start_valid = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
        if (res_valid) begin
          check($sformatf("b2b%0d gt", ridx), res_gt, pa[ridx] > pb[ridx]);
          check($sformatf("b2b%0d lt", ridx), res_lt, pa[ridx] < pb[ridx]);
          check($sformatf("b2b%0d eq", ridx), res_eq, pa[ridx] == pb[ridx]);
          ridx++;
          if (ridx == 10) done = 1'b1;
        end
        if (start_ready && idx < 10) begin
          if (idx > 0) check($sformatf("b2b%0d spacing", idx), c - last_acc, 7);
          last_acc = c;
          a = pa[idx];
          b = pb[idx];
          idx++;
        end
        if (!done) @(negedge clk);
      end
      start_valid = 1'b0;
      if (!done) check("b2b timeout results", ridx, 10);
      @(negedge clk);
      check("b2b idle", busy, 0);
    end

    // Comparator asserting gt and lt together on the last bit.
    run_op(4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "proto");
    @(negedge clk);
    run_op(4'b0110, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "sticky");
    @(negedge clk);
    check("sticky idle proto_err", proto_err, 1);
    reset = 1'b0;
    #1 check("proto_err cleared by reset", proto_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
